// File: rtl/axi_mmio_pkg.sv
// Shared definitions for the single-outstanding AXI4 MMIO manager:
// AXI constant codes, the FSM state type and default bus widths.
package axi_mmio_pkg;

    localparam int ADDR_W_DEF = 31;
    localparam int DATA_W_DEF = 64;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_AR,
        ST_RD_R,
        ST_WR_AWW,
        ST_WR_B,
        ST_RSP
    } state_t;

    // Sizes above 8 bytes cannot fit the 64-bit port and are rejected locally.
    function automatic logic cmd_bad(input logic [2:0] size, input logic [2:0] addr_lo);
        logic [3:0] mask;
        mask = (4'd1 << size) - 4'd1;
        return (size > 3'd3) || (({1'b0, addr_lo} & mask) != 4'd0);
    endfunction

endpackage

// File: rtl/axi_mmio_master.sv
// Converts a cmd/rsp handshake into single-beat AXI4 reads and writes,
// one transaction in flight at a time.
module axi_mmio_master
    import axi_mmio_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'h0,
    parameter int         ADDR_W = ADDR_W_DEF,
    parameter int         DATA_W = DATA_W_DEF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,

    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_W-1:0]     i_cmd_addr,
    input  logic [2:0]            i_cmd_size,
    input  logic [DATA_W-1:0]     i_cmd_wdata,
    input  logic [DATA_W/8-1:0]   i_cmd_wstrb,

    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic [1:0]            o_rsp_resp,

    output logic                  o_m_axi4_aw_valid,
    input  logic                  i_m_axi4_aw_ready,
    output logic [3:0]            o_m_axi4_aw_id,
    output logic [ADDR_W-1:0]     o_m_axi4_aw_addr,
    output logic [7:0]            o_m_axi4_aw_len,
    output logic [2:0]            o_m_axi4_aw_size,
    output logic [1:0]            o_m_axi4_aw_burst,

    output logic                  o_m_axi4_w_valid,
    input  logic                  i_m_axi4_w_ready,
    output logic [DATA_W-1:0]     o_m_axi4_w_data,
    output logic [DATA_W/8-1:0]   o_m_axi4_w_strb,
    output logic                  o_m_axi4_w_last,

    input  logic                  i_m_axi4_b_valid,
    output logic                  o_m_axi4_b_ready,
    input  logic [3:0]            i_m_axi4_b_id,
    input  logic [1:0]            i_m_axi4_b_resp,

    output logic                  o_m_axi4_ar_valid,
    input  logic                  i_m_axi4_ar_ready,
    output logic [3:0]            o_m_axi4_ar_id,
    output logic [ADDR_W-1:0]     o_m_axi4_ar_addr,
    output logic [7:0]            o_m_axi4_ar_len,
    output logic [2:0]            o_m_axi4_ar_size,
    output logic [1:0]            o_m_axi4_ar_burst,

    input  logic                  i_m_axi4_r_valid,
    output logic                  o_m_axi4_r_ready,
    input  logic [3:0]            i_m_axi4_r_id,
    input  logic [DATA_W-1:0]     i_m_axi4_r_data,
    input  logic [1:0]            i_m_axi4_r_resp,
    input  logic                  i_m_axi4_r_last
);

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_ar_valid, r_aw_valid, r_w_valid;
    logic                  r_aw_done, r_w_done;
    logic                  r_r_ready, r_b_ready;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic [1:0]            r_rsp_resp;
    logic [ADDR_W-1:0]     r_addr;
    logic [2:0]            r_size;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;

    logic w_aw_hs, w_w_hs, w_aw_fin, w_w_fin;

    assign w_aw_hs  = r_aw_valid & i_m_axi4_aw_ready;
    assign w_w_hs   = r_w_valid & i_m_axi4_w_ready;
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done | w_w_hs;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_ar_valid  <= 1'b0;
            r_aw_valid  <= 1'b0;
            r_w_valid   <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_r_ready   <= 1'b0;
            r_b_ready   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= AXI_RESP_OKAY;
            r_addr      <= '0;
            r_size      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (r_cmd_ready && i_cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= i_cmd_addr;
                        r_size      <= i_cmd_size;
                        r_wdata     <= i_cmd_wdata;
                        r_wstrb     <= i_cmd_wstrb;
                        if (cmd_bad(i_cmd_size, i_cmd_addr[2:0])) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_resp  <= AXI_RESP_SLVERR;
                            r_state     <= ST_RSP;
                        end else if (i_cmd_write) begin
                            r_aw_valid <= 1'b1;
                            r_w_valid  <= 1'b1;
                            r_aw_done  <= 1'b0;
                            r_w_done   <= 1'b0;
                            r_state    <= ST_WR_AWW;
                        end else begin
                            r_ar_valid <= 1'b1;
                            r_state    <= ST_RD_AR;
                        end
                    end
                end
                ST_RD_AR: begin
                    if (i_m_axi4_ar_ready) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (i_m_axi4_r_valid) begin
                        r_r_ready   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= i_m_axi4_r_data;
                        r_rsp_resp  <= (i_m_axi4_r_last && i_m_axi4_r_id == AXI_ID) ?
                                       i_m_axi4_r_resp : AXI_RESP_SLVERR;
                        r_state     <= ST_RSP;
                    end
                end
                ST_WR_AWW: begin
                    // aw and w complete independently; leave once both have.
                    if (w_aw_hs) begin
                        r_aw_valid <= 1'b0;
                        r_aw_done  <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_valid <= 1'b0;
                        r_w_done  <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_b_ready <= 1'b1;
                        r_state   <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (i_m_axi4_b_valid) begin
                        r_b_ready   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= (i_m_axi4_b_id == AXI_ID) ?
                                       i_m_axi4_b_resp : AXI_RESP_SLVERR;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_ready       = r_cmd_ready;
    assign o_rsp_valid       = r_rsp_valid;
    assign o_rsp_rdata       = r_rsp_rdata;
    assign o_rsp_resp        = r_rsp_resp;

    assign o_m_axi4_aw_valid = r_aw_valid;
    assign o_m_axi4_aw_id    = AXI_ID;
    assign o_m_axi4_aw_addr  = r_addr;
    assign o_m_axi4_aw_len   = 8'd0;
    assign o_m_axi4_aw_size  = r_size;
    assign o_m_axi4_aw_burst = AXI_BURST_INCR;

    assign o_m_axi4_w_valid  = r_w_valid;
    assign o_m_axi4_w_data   = r_wdata;
    assign o_m_axi4_w_strb   = r_wstrb;
    assign o_m_axi4_w_last   = 1'b1;

    assign o_m_axi4_b_ready  = r_b_ready;

    assign o_m_axi4_ar_valid = r_ar_valid;
    assign o_m_axi4_ar_id    = AXI_ID;
    assign o_m_axi4_ar_addr  = r_addr;
    assign o_m_axi4_ar_len   = 8'd0;
    assign o_m_axi4_ar_size  = r_size;
    assign o_m_axi4_ar_burst = AXI_BURST_INCR;

    assign o_m_axi4_r_ready  = r_r_ready;

endmodule

// File: tb/tb_axi_mmio_master.sv
// Directed plus randomized bench for axi_mmio_master; a scripted AXI slave
// drives each transaction and a rule-level model predicts every response.
module tb_axi_mmio_master;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_cmd_valid, o_cmd_ready, i_cmd_write;
    logic [30:0] i_cmd_addr;
    logic [2:0]  i_cmd_size;
    logic [63:0] i_cmd_wdata;
    logic [7:0]  i_cmd_wstrb;
    logic        o_rsp_valid, i_rsp_ready;
    logic [63:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic        o_aw_valid, i_aw_ready;
    logic [3:0]  o_aw_id;
    logic [30:0] o_aw_addr;
    logic [7:0]  o_aw_len;
    logic [2:0]  o_aw_size;
    logic [1:0]  o_aw_burst;
    logic        o_w_valid, i_w_ready;
    logic [63:0] o_w_data;
    logic [7:0]  o_w_strb;
    logic        o_w_last;
    logic        i_b_valid, o_b_ready;
    logic [3:0]  i_b_id;
    logic [1:0]  i_b_resp;
    logic        o_ar_valid, i_ar_ready;
    logic [3:0]  o_ar_id;
    logic [30:0] o_ar_addr;
    logic [7:0]  o_ar_len;
    logic [2:0]  o_ar_size;
    logic [1:0]  o_ar_burst;
    logic        i_r_valid, o_r_ready;
    logic [3:0]  i_r_id;
    logic [63:0] i_r_data;
    logic [1:0]  i_r_resp;
    logic        i_r_last;

    int checks = 0;
    int errors = 0;

    always #5 i_clock = ~i_clock;

    axi_mmio_master dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_size(i_cmd_size), .i_cmd_wdata(i_cmd_wdata),
        .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_resp(o_rsp_resp),
        .o_m_axi4_aw_valid(o_aw_valid), .i_m_axi4_aw_ready(i_aw_ready), .o_m_axi4_aw_id(o_aw_id),
        .o_m_axi4_aw_addr(o_aw_addr), .o_m_axi4_aw_len(o_aw_len), .o_m_axi4_aw_size(o_aw_size),
        .o_m_axi4_aw_burst(o_aw_burst),
        .o_m_axi4_w_valid(o_w_valid), .i_m_axi4_w_ready(i_w_ready), .o_m_axi4_w_data(o_w_data),
        .o_m_axi4_w_strb(o_w_strb), .o_m_axi4_w_last(o_w_last),
        .i_m_axi4_b_valid(i_b_valid), .o_m_axi4_b_ready(o_b_ready), .i_m_axi4_b_id(i_b_id),
        .i_m_axi4_b_resp(i_b_resp),
        .o_m_axi4_ar_valid(o_ar_valid), .i_m_axi4_ar_ready(i_ar_ready), .o_m_axi4_ar_id(o_ar_id),
        .o_m_axi4_ar_addr(o_ar_addr), .o_m_axi4_ar_len(o_ar_len), .o_m_axi4_ar_size(o_ar_size),
        .o_m_axi4_ar_burst(o_ar_burst),
        .i_m_axi4_r_valid(i_r_valid), .o_m_axi4_r_ready(o_r_ready), .i_m_axi4_r_id(i_r_id),
        .i_m_axi4_r_data(i_r_data), .i_m_axi4_r_resp(i_r_resp), .i_m_axi4_r_last(i_r_last)
    );

    typedef struct {
        bit          wr;
        logic [30:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        int          ar_dly, aw_dly, w_dly, rb_dly, rsp_dly;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        logic [3:0]  rid;
        bit          rlast;
        logic [1:0]  bresp;
        logic [3:0]  bid;
    } txn_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input bit wr, input logic [30:0] addr, input logic [2:0] size);
        txn_t t;
        t.wr = wr; t.addr = addr; t.size = size;
        t.wdata = 64'h0; t.wstrb = 8'h0;
        t.ar_dly = 0; t.aw_dly = 0; t.w_dly = 0; t.rb_dly = 0; t.rsp_dly = 0;
        t.rdata = 64'h0; t.rresp = 2'b00; t.rid = 4'h0; t.rlast = 1'b1;
        t.bresp = 2'b00; t.bid = 4'h0;
        return t;
    endfunction

    // What the caller should see, from the command and what the slave returns.
    function automatic void model(input txn_t t, output bit lerr,
                                  output logic [63:0] ed, output logic [1:0] er);
        lerr = (t.size > 3) || ((int'(t.addr) % (1 << t.size)) != 0);
        if (lerr) begin
            ed = 64'h0; er = 2'b10;
        end else if (!t.wr) begin
            ed = t.rdata;
            er = (t.rlast && t.rid == 4'h0) ? t.rresp : 2'b10;
        end else begin
            ed = 64'h0;
            er = (t.bid == 4'h0) ? t.bresp : 2'b10;
        end
    endfunction

    task automatic run(input txn_t t);
        bit lerr, awd, wd;
        logic [63:0] ed;
        logic [1:0] er;
        int n;
        model(t, lerr, ed, er);
        n = 0;
        while (o_cmd_ready !== 1'b1 && n < 20) begin @(negedge i_clock); n++; end
        chk("cmd_ready_idle", o_cmd_ready, 1);
        chk("r_ready_idle", o_r_ready, 0);
        chk("b_ready_idle", o_b_ready, 0);
        i_cmd_valid = 1'b1; i_cmd_write = t.wr; i_cmd_addr = t.addr; i_cmd_size = t.size;
        i_cmd_wdata = t.wdata; i_cmd_wstrb = t.wstrb;
        @(negedge i_clock);
        i_cmd_valid = 1'b0;
        // scramble cmd fields: the DUT must work from its own copies
        i_cmd_addr = 31'($urandom); i_cmd_size = 3'($urandom); i_cmd_write = ~t.wr;
        i_cmd_wdata = {$urandom, $urandom}; i_cmd_wstrb = 8'($urandom);
        chk("cmd_ready_busy", o_cmd_ready, 0);
        if (lerr) begin
            chk("err_no_ar", o_ar_valid, 0);
            chk("err_no_aw", o_aw_valid, 0);
            chk("err_no_w", o_w_valid, 0);
        end else if (!t.wr) begin
            chk("ar_valid", o_ar_valid, 1);
            chk("ar_addr", o_ar_addr, t.addr);
            chk("ar_size", o_ar_size, t.size);
            chk("ar_len", o_ar_len, 0);
            chk("ar_burst", o_ar_burst, 2'b01);
            chk("ar_id", o_ar_id, 0);
            chk("rd_no_aw", o_aw_valid, 0);
            repeat (t.ar_dly) begin
                @(negedge i_clock);
                chk("ar_hold", o_ar_valid, 1);
                chk("ar_addr_stable", o_ar_addr, t.addr);
                chk("r_ready_early", o_r_ready, 0);
            end
            i_ar_ready = 1'b1;
            @(negedge i_clock);
            i_ar_ready = 1'b0;
            chk("ar_drop", o_ar_valid, 0);
            chk("r_ready", o_r_ready, 1);
            repeat (t.rb_dly) @(negedge i_clock);
            i_r_valid = 1'b1; i_r_data = t.rdata; i_r_resp = t.rresp;
            i_r_id = t.rid; i_r_last = t.rlast;
            @(negedge i_clock);
            i_r_valid = 1'b0;
            chk("r_ready_drop", o_r_ready, 0);
        end else begin
            chk("aw_valid", o_aw_valid, 1);
            chk("w_valid", o_w_valid, 1);
            chk("aw_addr", o_aw_addr, t.addr);
            chk("aw_size", o_aw_size, t.size);
            chk("aw_len", o_aw_len, 0);
            chk("aw_burst", o_aw_burst, 2'b01);
            chk("aw_id", o_aw_id, 0);
            chk("w_data", o_w_data, t.wdata);
            chk("w_strb", o_w_strb, t.wstrb);
            chk("w_last", o_w_last, 1);
            awd = 1'b0; wd = 1'b0; n = 0;
            while (!(awd && wd) && n < 40) begin
                i_aw_ready = !awd && n >= t.aw_dly;
                i_w_ready  = !wd && n >= t.w_dly;
                chk("b_ready_early", o_b_ready, 0);
                @(negedge i_clock);
                n++;
                if (i_aw_ready) awd = 1'b1;
                if (i_w_ready) wd = 1'b1;
                chk("aw_valid_track", o_aw_valid, !awd);
                chk("w_valid_track", o_w_valid, !wd);
                i_aw_ready = 1'b0; i_w_ready = 1'b0;
            end
            chk("aww_complete", awd && wd, 1);
            chk("b_ready", o_b_ready, 1);
            repeat (t.rb_dly) @(negedge i_clock);
            i_b_valid = 1'b1; i_b_resp = t.bresp; i_b_id = t.bid;
            @(negedge i_clock);
            i_b_valid = 1'b0;
            chk("b_ready_drop", o_b_ready, 0);
        end
        chk("rsp_valid", o_rsp_valid, 1);
        chk("rsp_rdata", o_rsp_rdata, ed);
        chk("rsp_resp", o_rsp_resp, er);
        repeat (t.rsp_dly) begin
            @(negedge i_clock);
            chk("rsp_hold", o_rsp_valid, 1);
            chk("rsp_rdata_stable", o_rsp_rdata, ed);
            chk("rsp_resp_stable", o_rsp_resp, er);
            chk("cmd_ready_in_rsp", o_cmd_ready, 0);
        end
        i_rsp_ready = 1'b1;
        @(negedge i_clock);
        i_rsp_ready = 1'b0;
        chk("rsp_drop", o_rsp_valid, 0);
        chk("cmd_ready_after_rsp", o_cmd_ready, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        txn_t t;
        i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0;
        i_cmd_size = '0; i_cmd_wdata = '0; i_cmd_wstrb = '0; i_rsp_ready = 1'b0;
        i_aw_ready = 1'b0; i_w_ready = 1'b0; i_b_valid = 1'b0; i_b_id = '0; i_b_resp = '0;
        i_ar_ready = 1'b0; i_r_valid = 1'b0; i_r_id = '0; i_r_data = '0; i_r_resp = '0;
        i_r_last = 1'b0;
        repeat (3) @(negedge i_clock);
        chk("rst_ar_valid", o_ar_valid, 0);
        chk("rst_aw_valid", o_aw_valid, 0);
        chk("rst_w_valid", o_w_valid, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_r_ready", o_r_ready, 0);
        chk("rst_b_ready", o_b_ready, 0);
        chk("rst_rdata", o_rsp_rdata, 0);
        chk("rst_resp", o_rsp_resp, 0);
        i_reset = 1'b0;
        @(negedge i_clock);
        chk("rst_cmd_ready", o_cmd_ready, 1);

        // read with ar_ready held off three cycles
        t = mk(1'b0, 31'h60010008, 3'd3);
        t.ar_dly = 3; t.rdata = 64'hDEAD_BEEF_0123_4567;
        run(t);

        // write: w accepted at once, aw two cycles later
        t = mk(1'b1, 31'h60000004, 3'd2);
        t.wdata = 64'h1122_3344_0000_0000; t.wstrb = 8'hF0; t.aw_dly = 2;
        run(t);

        // write: aw and w in the same cycle, DECERR back
        t = mk(1'b1, 31'h60000010, 3'd3);
        t.wdata = 64'hCAFE_F00D_5555_AAAA; t.wstrb = 8'hFF;
        t.aw_dly = 1; t.w_dly = 1; t.bresp = 2'b11;
        run(t);

        // misaligned read: no bus activity
        t = mk(1'b0, 31'h60000003, 3'd1);
        run(t);

        // response back-pressure
        t = mk(1'b0, 31'h60000020, 3'd2);
        t.rdata = 64'h0000_0000_A5A5_5A5A; t.rresp = 2'b01; t.rsp_dly = 5;
        run(t);

        // oversize, bad r_id, missing r_last, bad b_id, aw before w
        t = mk(1'b1, 31'h60000000, 3'd4);
        run(t);
        t = mk(1'b0, 31'h60000040, 3'd3);
        t.rdata = 64'h1357_9BDF_2468_ACE0; t.rid = 4'h3;
        run(t);
        t = mk(1'b0, 31'h60000048, 3'd3);
        t.rdata = 64'h0F0F_0F0F_0F0F_0F0F; t.rlast = 1'b0;
        run(t);
        t = mk(1'b1, 31'h60000050, 3'd0);
        t.wdata = 64'h77; t.wstrb = 8'h01; t.w_dly = 3; t.bid = 4'h9;
        run(t);

        // reset while the write is waiting for aw/w
        @(negedge i_clock);
        i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 31'h60000100;
        i_cmd_size = 3'd3; i_cmd_wdata = 64'h1; i_cmd_wstrb = 8'hFF;
        @(negedge i_clock);
        i_cmd_valid = 1'b0;
        chk("mid_aw_valid", o_aw_valid, 1);
        @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        chk("mid_rst_aw_valid", o_aw_valid, 0);
        chk("mid_rst_w_valid", o_w_valid, 0);
        chk("mid_rst_ar_valid", o_ar_valid, 0);
        chk("mid_rst_rsp_valid", o_rsp_valid, 0);
        chk("mid_rst_b_ready", o_b_ready, 0);
        chk("mid_rst_r_ready", o_r_ready, 0);
        i_reset = 1'b0;
        @(negedge i_clock);
        chk("mid_rst_cmd_ready", o_cmd_ready, 1);

        for (int k = 0; k < 40; k++) begin
            t = mk($urandom_range(0, 1) == 1, 31'($urandom),
                   ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
                                               : 3'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) != 0)
                t.addr = t.addr & ~31'((1 << t.size) - 1);
            t.wdata = {$urandom, $urandom}; t.wstrb = 8'($urandom);
            t.ar_dly = $urandom_range(0, 3); t.aw_dly = $urandom_range(0, 3);
            t.w_dly = $urandom_range(0, 3); t.rb_dly = $urandom_range(0, 3);
            t.rsp_dly = $urandom_range(0, 2);
            t.rdata = {$urandom, $urandom}; t.rresp = 2'($urandom);
            t.rid = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            t.rlast = ($urandom_range(0, 7) != 0);
            t.bresp = 2'($urandom);
            t.bid = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            run(t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
